// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared core types and widths for the writeback path.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_e;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] a);
    return a == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_if
// Brief   : Result sources, MDU issue, register-file write port and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
  parameter int XLEN = cpu_pkg::XLEN
);
  import cpu_pkg::*;

  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_data;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_data;
  logic                  mdu_ready;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  wen;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       wdata;
  logic [NUM_REGS-1:0]   busy;
  logic                  stall_req;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  issue_valid, issue_rd,
    output mdu_ready, wen, rd, wdata, busy, stall_req
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output mdu_valid, mdu_rd, mdu_data,
    output issue_valid, issue_rd,
    input  mdu_ready, wen, rd, wdata, busy, stall_req
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Power-of-two synchronous FIFO, extra pointer bit for full/empty.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Brief   : Register-file write-port arbiter: pipeline vs buffered MDU results.
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int MDU_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  wb_arbiter_if.slave bus
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    c_cnt_one   = 1;
  localparam logic [CNT_W-1:0]    c_starve    = CNT_W'(STARVE_MAX);
  localparam logic [NUM_REGS-1:0] c_reg_bit0  = 1;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_head;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;
  wb_src_e               w_src;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic [CNT_W-1:0]      w_starve_nxt;
  logic [NUM_REGS-1:0]   w_busy_set;
  logic [NUM_REGS-1:0]   w_busy_clr;

  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wdata;
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_stall;
  logic [CNT_W-1:0]      r_starve;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (MDU_DEPTH)
  ) u_mdu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({bus.mdu_rd, bus.mdu_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_rd, w_head_data} = w_head;

  // Held low in reset so the MDU never hands off a result that would be lost.
  assign bus.mdu_ready = rst_n & ~w_full;
  assign w_acc         = bus.mdu_valid & bus.mdu_ready;

  always_comb begin
    w_src = SRC_NONE;
    if (r_stall && !w_empty)  w_src = SRC_FIFO;
    else if (bus.pipe_valid)  w_src = SRC_PIPE;
    else if (!w_empty)        w_src = SRC_FIFO;
    else if (w_acc)           w_src = SRC_BYP;
  end

  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    case (w_src)
      SRC_PIPE: begin w_sel_rd = bus.pipe_rd; w_sel_data = bus.pipe_data; end
      SRC_FIFO: begin w_sel_rd = w_head_rd;   w_sel_data = w_head_data;   end
      SRC_BYP:  begin w_sel_rd = bus.mdu_rd;  w_sel_data = bus.mdu_data;  end
      default:  ;
    endcase
  end

  assign w_pop  = (w_src == SRC_FIFO);
  assign w_push = w_acc && (w_src != SRC_BYP);

  assign w_starve_nxt = (w_src == SRC_PIPE && !w_empty) ? r_starve + c_cnt_one : '0;

  assign w_busy_set = (bus.issue_valid && !is_x0(bus.issue_rd)) ? (c_reg_bit0 << bus.issue_rd) : '0;
  assign w_busy_clr = (w_src == SRC_FIFO || w_src == SRC_BYP) ? (c_reg_bit0 << w_sel_rd) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen    <= 1'b0;
      r_rd     <= '0;
      r_wdata  <= '0;
      r_busy   <= '0;
      r_stall  <= 1'b0;
      r_starve <= '0;
    end else begin
      r_wen <= (w_src != SRC_NONE) && !is_x0(w_sel_rd);
      if (w_src != SRC_NONE) begin
        r_rd    <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
      // Set has priority so a re-issue racing the old result stays pending.
      r_busy   <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~c_reg_bit0;
      r_starve <= w_starve_nxt;
      if (w_starve_nxt == c_starve) r_stall <= 1'b1;
      else if (w_pop)               r_stall <= 1'b0;
    end
  end

  assign bus.wen       = r_wen;
  assign bus.rd        = r_rd;
  assign bus.wdata     = r_wdata;
  assign bus.busy      = r_busy;
  assign bus.stall_req = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Self-checking bench for wb_arbiter against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_arbiter_if #(.XLEN(XLEN)) bus();

  wb_arbiter #(
    .XLEN       (XLEN),
    .MDU_DEPTH  (DEPTH),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  wb_entry_t   mq[$];
  logic        m_stall;
  int          m_cnt;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  function automatic logic m_ready();
    return mq.size() < DEPTH;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall = 1'b0; m_cnt = 0; m_busy = '0;
    m_wen = 1'b0; m_rd = '0; m_wdata = '0;
  endtask

  task automatic apply(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird, output logic acc);
    wb_entry_t e;
    int        src;
    logic      had;
    bus.pipe_valid = pv;  bus.pipe_rd = prd;  bus.pipe_data = pd;
    bus.mdu_valid  = mv;  bus.mdu_rd  = mrd;  bus.mdu_data  = md;
    bus.issue_valid = iv; bus.issue_rd = ird;
    acc = mv && m_ready();
    had = mq.size() > 0;
    src = 0;
    e   = '0;
    if (m_stall && had) src = 2;
    else if (pv)        src = 1;
    else if (had)       src = 2;
    else if (acc)       src = 3;
    if (src == 1) e = '{rd: prd, data: pd};
    if (src == 2) e = mq.pop_front();
    if (src == 3) e = '{rd: mrd, data: md};
    if (acc && src != 3) mq.push_back('{rd: mrd, data: md});
    if (src == 1 && had) m_cnt++; else m_cnt = 0;
    if (m_cnt == STARVE) m_stall = 1'b1;
    else if (src == 2)   m_stall = 1'b0;
    if (src >= 2) m_busy[e.rd] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
    m_busy[0] = 1'b0;
    if (src != 0) begin m_wen = (e.rd != 0); m_rd = e.rd; m_wdata = e.data; end
    else m_wen = 1'b0;
  endtask

  task automatic idle();
    logic acc;
    apply(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  // Advances one clock; the pipeline must never present a result while stalled.
  task automatic tick();
    if (rst_n === 1'b1 && bus.pipe_valid === 1'b1 && bus.stall_req === 1'b1) begin
      n_fail++;
      $display("FAIL protocol: pipe_valid=1 while stall_req=1 at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pipe_valid = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.wen, bus.rd, bus.wdata, bus.busy, bus.stall_req} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got wen=%b rd=%0d wdata=%h busy=%h stall=%b, want all 0",
                               bus.wen, bus.rd, bus.wdata, bus.busy, bus.stall_req); end
    n_tests++;
    if (bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", bus.mdu_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b want 1", bus.mdu_ready); end
    idle();
    tick();
    n_tests++;
    if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL reset_no_write: got wen=%b want 0", bus.wen); end
  endtask

  task automatic test_pipe_only();
    logic acc;
    apply(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
    tick();
    n_tests++;
    if ({bus.wen, bus.rd, bus.wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL pipe_write: got wen=%b rd=%0d wdata=%h want 1/5/deadbeef", bus.wen, bus.rd, bus.wdata); end
    apply(1, 0, 32'hCAFE0000, 0, 0, 0, 0, 0, acc);
    tick();
    n_tests++;
    if ({bus.wen, bus.rd} !== {1'b0, 5'd0})
      begin n_fail++; $display("FAIL pipe_x0: got wen=%b rd=%0d want 0/0", bus.wen, bus.rd); end
    idle();
    tick();
    n_tests++;
    if ({bus.wen, bus.wdata} !== {1'b0, 32'hCAFE0000})
      begin n_fail++; $display("FAIL pipe_hold: got wen=%b wdata=%h want 0/cafe0000", bus.wen, bus.wdata); end
  endtask

  task automatic test_bypass();
    logic acc;
    apply(0, 0, 0, 0, 0, 0, 1, 7, acc);
    tick();
    n_tests++;
    if ({bus.busy[7], bus.wen, bus.mdu_ready} !== 3'b101)
      begin n_fail++; $display("FAIL bypass_issue: got busy7=%b wen=%b rdy=%b want 1/0/1", bus.busy[7], bus.wen, bus.mdu_ready); end
    apply(0, 0, 0, 1, 7, 32'h12345678, 0, 0, acc);
    tick();
    n_tests++;
    if ({bus.wen, bus.rd, bus.wdata, bus.busy[7]} !== {1'b1, 5'd7, 32'h12345678, 1'b0})
      begin n_fail++; $display("FAIL bypass_write: got wen=%b rd=%0d wdata=%h busy7=%b want 1/7/12345678/0",
                               bus.wen, bus.rd, bus.wdata, bus.busy[7]); end
    idle();
    tick();
  endtask

  task automatic test_scoreboard_race();
    logic acc;
    apply(0, 0, 0, 0, 0, 0, 1, 9, acc);
    tick();
    apply(0, 0, 0, 1, 9, 32'hA5A5A5A5, 1, 9, acc);
    tick();
    n_tests++;
    if ({bus.wen, bus.rd, bus.busy[9]} !== {1'b1, 5'd9, 1'b1})
      begin n_fail++; $display("FAIL race_set_wins: got wen=%b rd=%0d busy9=%b want 1/9/1", bus.wen, bus.rd, bus.busy[9]); end
    apply(0, 0, 0, 1, 9, 32'h5A5A5A5A, 0, 0, acc);
    tick();
    n_tests++;
    if ({bus.wdata, bus.busy[9]} !== {32'h5A5A5A5A, 1'b0})
      begin n_fail++; $display("FAIL race_clear: got wdata=%h busy9=%b want 5a5a5a5a/0", bus.wdata, bus.busy[9]); end
    idle();
    tick();
  endtask

  task automatic test_contention();
    logic acc;
    int   idx = 0;
    int   ready_drop_idx = -1;
    int   stall_cyc = -1;
    int   wr_rd[$];
    int   wr_cyc[$];
    logic pv;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 1, 5'(10 + i), acc);
      tick();
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      pv = (stall_cyc < 0) && !m_stall;
      apply(pv, 1, 32'(cyc), idx < 3, 5'(10 + idx), 32'hC0DE0000 + 32'(idx), 0, 0, acc);
      if (acc) idx++;
      tick();
      n_tests++;
      if ({bus.wen, bus.rd, bus.wdata, bus.busy, bus.stall_req, bus.mdu_ready} !==
          {m_wen, m_rd, m_wdata, m_busy, m_stall, m_ready()})
        begin n_fail++; $display("FAIL contention_cycle%0d: got wen=%b rd=%0d wdata=%h busy=%h stall=%b rdy=%b want %b/%0d/%h/%h/%b/%b",
                                 cyc, bus.wen, bus.rd, bus.wdata, bus.busy, bus.stall_req, bus.mdu_ready,
                                 m_wen, m_rd, m_wdata, m_busy, m_stall, m_ready()); end
      if (bus.mdu_ready === 1'b0 && ready_drop_idx < 0) ready_drop_idx = idx;
      if (bus.stall_req === 1'b1 && stall_cyc < 0) stall_cyc = cyc;
      if (bus.wen === 1'b1 && bus.rd >= 10) begin wr_rd.push_back(int'(bus.rd)); wr_cyc.push_back(cyc); end
    end
    n_tests++;
    if (ready_drop_idx !== 2) begin n_fail++; $display("FAIL contention_ready_drop: accepts=%0d want 2", ready_drop_idx); end
    n_tests++;
    if (stall_cyc !== 4) begin n_fail++; $display("FAIL contention_stall_rise: cycle=%0d want 4", stall_cyc); end
    n_tests++;
    if (wr_rd.size() != 3) begin n_fail++; $display("FAIL contention_drain_count: got %0d want 3", wr_rd.size()); end
    else if (wr_rd[0] != 10 || wr_rd[1] != 11 || wr_rd[2] != 12 ||
             wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1)
      begin n_fail++; $display("FAIL contention_drain_order: rds %0d,%0d,%0d at %0d,%0d,%0d want 10,11,12 consecutive",
                               wr_rd[0], wr_rd[1], wr_rd[2], wr_cyc[0], wr_cyc[1], wr_cyc[2]); end
    n_tests++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL contention_stall_clear: got %b want 0", bus.stall_req); end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    apply(0, 0, 0, 0, 0, 0, 1, 20, acc); tick();
    apply(0, 0, 0, 0, 0, 0, 1, 21, acc); tick();
    apply(1, 2, 32'h22, 1, 20, 32'h2020, 0, 0, acc); tick();
    apply(1, 3, 32'h33, 1, 21, 32'h2121, 0, 0, acc); tick();
    n_tests++;
    if ({bus.wen, bus.mdu_ready, bus.busy[20], bus.busy[21]} !== 4'b1011)
      begin n_fail++; $display("FAIL midreset_prefill: got wen=%b rdy=%b busy20=%b busy21=%b want 1/0/1/1",
                               bus.wen, bus.mdu_ready, bus.busy[20], bus.busy[21]); end
    bus.pipe_valid = 0; bus.mdu_valid = 0; bus.issue_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.wen, bus.busy, bus.stall_req, bus.mdu_ready} !== '0)
      begin n_fail++; $display("FAIL midreset_async: got wen=%b busy=%h stall=%b rdy=%b want all 0",
                               bus.wen, bus.busy, bus.stall_req, bus.mdu_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", bus.mdu_ready); end
    for (int i = 0; i < 4; i++) begin
      idle();
      tick();
      n_tests++;
      if ({bus.wen, bus.busy, bus.stall_req, bus.mdu_ready} !== {m_wen, m_busy, m_stall, m_ready()})
        begin n_fail++; $display("FAIL midreset_stale%0d: got wen=%b rd=%0d busy=%h want wen=0 busy=0", i, bus.wen, bus.rd, bus.busy); end
    end
  endtask

  task automatic test_wrap_random();
    logic [4:0]  rds[10];
    logic [31:0] dat[10];
    wb_entry_t   exp_q[$];
    wb_entry_t   got_q[$];
    logic        acc, pv, iv, mv;
    int          n_iss = 0;
    int          n_off = 0;
    int          burst = 0;
    bit          done = 0;
    for (int i = 0; i < 10; i++) begin
      rds[i] = 5'($urandom_range(0, 31));
      dat[i] = $urandom() | 32'h8000_0000;
      if (rds[i] != 0) exp_q.push_back('{rd: rds[i], data: dat[i]});
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (burst == 0 && $urandom_range(0, 5) == 0) burst = int'($urandom_range(1, 5));
      pv = (burst > 0) && !m_stall;
      if (burst > 0) burst--;
      iv = (n_iss < 10) && ($urandom_range(0, 1) == 1);
      mv = (n_off < n_iss) && ($urandom_range(0, 3) != 0);
      apply(pv, 5'($urandom_range(0, 31)), $urandom() & 32'h7FFF_FFFF,
            mv, rds[n_off % 10], dat[n_off % 10], iv, rds[n_iss % 10], acc);
      if (iv)  n_iss++;
      if (acc) n_off++;
      tick();
      n_tests++;
      if ({bus.wen, bus.rd, bus.wdata, bus.busy, bus.stall_req, bus.mdu_ready} !==
          {m_wen, m_rd, m_wdata, m_busy, m_stall, m_ready()})
        begin n_fail++; $display("FAIL wrap_cycle%0d: got wen=%b rd=%0d wdata=%h busy=%h stall=%b rdy=%b want %b/%0d/%h/%h/%b/%b",
                                 cyc, bus.wen, bus.rd, bus.wdata, bus.busy, bus.stall_req, bus.mdu_ready,
                                 m_wen, m_rd, m_wdata, m_busy, m_stall, m_ready()); end
      if (bus.wen === 1'b1 && bus.wdata[31] === 1'b1) got_q.push_back('{rd: bus.rd, data: bus.wdata});
      done = (n_off == 10) && (mq.size() == 0);
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL wrap_timeout: delivered %0d of 10 within budget", n_off); end
    n_tests++;
    if (got_q.size() != exp_q.size())
      begin n_fail++; $display("FAIL wrap_count: got %0d MDU writes want %0d", got_q.size(), exp_q.size()); end
    else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i])
          begin n_fail++; $display("FAIL wrap_order%0d: got rd=%0d data=%h want rd=%0d data=%h",
                                   i, got_q[i].rd, got_q[i].data, exp_q[i].rd, exp_q[i].data); end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_bypass();
    test_scoreboard_race();
    test_contention();
    test_reset_midstream();
    test_wrap_random();
    test_wrap_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
